// File: rtl/nonogram_stream_parser.sv
// nonogram_stream_parser
// Converts the uart byte stream that describes a nonogram (N, M, then one
// count+clues record per row and per column) into 13-bit BRAM words: one
// header word per line and one word per clue. The board is checked while it
// streams in; a board-done pulse tells the solver the BRAM image is complete.
module nonogram_stream_parser #(
   parameter int MAX_DIM    = 64,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  axiiv,
   input  logic [7:0]            axiid,
   output logic                  axiovl,
   output logic [12:0]           axiod,
   output logic [ADDR_WIDTH-1:0] axioa,
   output logic                  axiov,
   output logic                  err,
   output logic [7:0]            n_rows,
   output logic [7:0]            n_cols,
   output logic [ADDR_WIDTH-1:0] word_count
);

   typedef enum logic [2:0] {
      S_GET_N,
      S_GET_M,
      S_GET_K,
      S_GET_CLUE,
      S_DONE,
      S_ERR
   } state_e;

   state_e                state_q;
   logic [7:0]            n_rows_q;
   logic [7:0]            n_cols_q;
   logic [7:0]            line_idx_q;
   logic [7:0]            used_q;
   logic [7:0]            remain_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] word_count_q;
   logic [ADDR_WIDTH-1:0] axioa_q;
   logic [12:0]           axiod_q;
   logic                  axiovl_q;
   logic                  axiov_q;
   logic                  err_q;

   logic                  dim_ok;
   logic [7:0]            line_len;
   logic [8:0]            k_max;
   logic                  k_too_big;
   logic [8:0]            used_d;
   logic                  clue_bad;
   logic                  last_line;
   logic                  addr_full;

   // Rows are M cells long, columns are N cells long.
   assign dim_ok    = (axiid != 8'd0) && (32'(axiid) <= MAX_DIM);
   assign line_len  = (line_idx_q < n_rows_q) ? n_cols_q : n_rows_q;
   // K clues need at least K cells plus K-1 gaps, so K <= (len+1)/2.
   assign k_max     = ({1'b0, line_len} + 9'd1) >> 1;
   assign k_too_big = {1'b0, axiid} > k_max;
   // Clues are never zero, so used_q == 0 identifies the first clue of a line
   // (no leading gap). Computed at 9 bits so a large clue cannot wrap.
   assign used_d    = {1'b0, used_q} + {1'b0, axiid} + ((used_q == 8'd0) ? 9'd0 : 9'd1);
   assign clue_bad  = (axiid == 8'd0) || (used_d > {1'b0, line_len});
   assign last_line = ({1'b0, line_idx_q} + 9'd1) == ({1'b0, n_rows_q} + {1'b0, n_cols_q});
   // A write at the all-ones address would push the counter past its range.
   assign addr_full = &addr_q;

   // Parser FSM with registered BRAM write port and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_GET_N;
         n_rows_q     <= '0;
         n_cols_q     <= '0;
         line_idx_q   <= '0;
         used_q       <= '0;
         remain_q     <= '0;
         addr_q       <= '0;
         word_count_q <= '0;
         axioa_q      <= '0;
         axiod_q      <= '0;
         axiovl_q     <= 1'b0;
         axiov_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only here, so every right-hand side
         // sees the pre-edge register values regardless of statement order.
         axiovl_q <= 1'b0;
         axiov_q  <= 1'b0;
         case (state_q)
            // DONE shares byte handling with GET_N so a new N arriving in the
            // done cycle is not lost.
            S_GET_N, S_DONE: begin
               if (state_q == S_DONE) begin
                  axiov_q      <= 1'b1;
                  word_count_q <= addr_q;
                  addr_q       <= '0;
                  state_q      <= S_GET_N;
               end
               if (axiiv) begin
                  if (dim_ok) begin
                     n_rows_q <= axiid;
                     state_q  <= S_GET_M;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end
               end
            end
            S_GET_M: begin
               if (axiiv) begin
                  if (dim_ok) begin
                     n_cols_q   <= axiid;
                     line_idx_q <= '0;
                     state_q    <= S_GET_K;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end
               end
            end
            S_GET_K: begin
               if (axiiv) begin
                  if (k_too_big || addr_full) begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end else begin
                     axiovl_q <= 1'b1;
                     axiod_q  <= {1'b1, 4'b0000, line_idx_q};
                     axioa_q  <= addr_q;
                     addr_q   <= addr_q + 1'b1;
                     if (axiid == 8'd0) begin
                        line_idx_q <= line_idx_q + 8'd1;
                        state_q    <= last_line ? S_DONE : S_GET_K;
                     end else begin
                        used_q   <= '0;
                        remain_q <= axiid;
                        state_q  <= S_GET_CLUE;
                     end
                  end
               end
            end
            S_GET_CLUE: begin
               if (axiiv) begin
                  if (clue_bad || addr_full) begin
                     err_q   <= 1'b1;
                     state_q <= S_ERR;
                  end else begin
                     axiovl_q <= 1'b1;
                     axiod_q  <= {5'b00000, axiid};
                     axioa_q  <= addr_q;
                     addr_q   <= addr_q + 1'b1;
                     used_q   <= used_d[7:0];
                     remain_q <= remain_q - 8'd1;
                     if (remain_q == 8'd1) begin
                        line_idx_q <= line_idx_q + 8'd1;
                        state_q    <= last_line ? S_DONE : S_GET_K;
                     end
                  end
               end
            end
            // Sticky error: ignore everything until reset.
            S_ERR: begin
               err_q <= 1'b1;
            end
            default: begin
               err_q   <= 1'b1;
               state_q <= S_ERR;
            end
         endcase
      end
   end

   assign axiovl     = axiovl_q;
   assign axiod      = axiod_q;
   assign axioa      = axioa_q;
   assign axiov      = axiov_q;
   assign err        = err_q;
   assign n_rows     = n_rows_q;
   assign n_cols     = n_cols_q;
   assign word_count = word_count_q;

endmodule

// File: doc/nonogram_stream_parser.md
Name: nonogram_stream_parser

Overview:
- Sits between uart_rx and the puzzle BRAM. It consumes the received byte stream that describes a nonogram: the dimensions, then the clue lists for every row and then every column.
- Emits one 13-bit BRAM word per line header and per clue, together with a write address and strobe.
- Validates the puzzle on the fly and signals board-complete to the downstream solver.

Parameters:
MAX_DIM, 64, largest legal row count N and column count M (1..MAX_DIM).
ADDR_WIDTH, 16, width of BRAM write address and word counter.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
axiiv  in  1  byte-valid strobe from uart_rx, single cycle, may assert every cycle
axiid  in  8  received byte, sampled when axiiv=1
axiovl  out  1  BRAM write strobe, one cycle per word
axiod  out  13  BRAM write data
axioa  out  ADDR_WIDTH  BRAM write address for axiod
axiov  out  1  board-done pulse, one cycle
err  out  1  sticky format-error flag
n_rows  out  8  latched N
n_cols  out  8  latched M
word_count  out  ADDR_WIDTH  total words written, valid when axiov=1

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state GET_N, address counter 0.
- Input byte order: N, M, then N+M line records in order rows 0..N-1 followed by cols 0..M-1. Each record is a count byte K followed by K clue bytes.
- Line index and length:
  - Rows take indices 0..N-1 and have length M.
  - Columns take indices N..N+M-1 and have length N.
- Word format:
  - Header word = {1'b1, line_idx[11:0]}.
  - Clue word = {1'b0, 4'b0, clue[7:0]}.
- Timing: registered outputs, latency 1. A byte accepted in cycle t produces axiovl/axiod/axioa in cycle t+1. axioa equals the number of words previously written. The address increments after each write.
- No backpressure: back-to-back axiiv on consecutive cycles must be accepted without loss.
- FSM states:
  - GET_N: on byte, N in 1..MAX_DIM -> latch n_rows, go GET_M; otherwise go ERR.
  - GET_M: same check against MAX_DIM -> latch n_cols, line_idx=0, go GET_K.
  - GET_K:
    - On byte K, write the header word for line_idx.
    - K=0 -> empty line, advance the line.
    - K>0 -> clear used and remaining=K, go GET_CLUE.
    - K > (len+1)/2 (integer division) -> ERR, no header written.
  - GET_CLUE:
    - clue=0 -> ERR.
    - used_next = used + clue + (first clue ? 0 : 1). used_next > len -> ERR, clue not written.
    - Otherwise write the clue word and decrement remaining. At 0, advance the line.
  - Advance line: line_idx+1. If the new line_idx == N+M, go DONE; otherwise go GET_K.
  - DONE:
    - axiov=1 for exactly one cycle, the cycle after the final write.
    - word_count = final address.
    - Return to GET_N. n_rows/n_cols hold until the next N is latched.
    - A byte arriving in the DONE cycle is accepted as the next N.
  - ERR:
    - err=1, sticky. All further bytes are ignored, and no axiovl or axiov is issued.
    - Exit only via rst_n.
- Widths:
  - used is 8 bits plus carry; comparison is done at 9 bits so no wrap.
  - line_idx is 8 bits, max 2*MAX_DIM-1.
- Address wrap: if the address counter would pass 2^ADDR_WIDTH-1 -> ERR. This is unreachable with the defaults.
- Reset mid-stream: immediate return to GET_N. A partially written board is abandoned, with no axiov and address back to 0.
- An axiiv pulse coincident with rst_n low is dropped.

Test Plan:
- Valid 2x3 board, bytes 02 03 | 01 03 | 02 01 01 | 01 02 | 00 | 01 02, at one byte per 10 cycles. Required response:
  - Writes at addr0..9: 0x1000, 0x0003, 0x1001, 0x0001, 0x0001, 0x1002, 0x0002, 0x1003, 0x1004, 0x0002.
  - axiov one cycle after the addr9 write, word_count=10, n_rows=2, n_cols=3, err=0.
- Same stream with axiiv asserted on consecutive cycles -> identical write sequence, each write exactly one cycle after its byte.
- Overfull row: 01 03 | 02 02 02 -> header 0x1000 and clue 0x0002 written, then err=1, no third write, axiov never asserts. Further bytes produce no writes.
- Bad dimension: first byte 0x00 (and separately 0x41 with MAX_DIM=64) -> err=1, zero writes.
- Reset mid-stream: drop rst_n after the 3rd write, release, send a valid 1x1 board 01 01 | 01 01 | 01 01 -> writes 0x1000, 0x0001, 0x1001, 0x0001 at addr0..3, axiov pulses, word_count=4, err=0.
- Two boards back-to-back, the second N arriving in the DONE cycle -> second board is parsed, addresses restart at 0, two separate axiov pulses.
